// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: multi-cycle mult/div with a pending result committed to HI/LO,
// single-edge mthi/mtlo, abort on interrupt of the issuing op. MDU_MADD_EN enables madd/msub (op 6/7).
module e_mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        IntReq,
   output logic        busy,
   output logic        md_stall,
   output logic [31:0] HI,
   output logic [31:0] LO
);
   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = ($clog2(MAXC + 1) < 4) ? 4 : $clog2(MAXC + 1);

   typedef enum logic {IDLE, RUN} state_t;
   // How the pending result lands in HI/LO at the completion edge
   typedef enum logic [1:0] {WR_SET, WR_ADD, WR_SUB, WR_NONE} wr_t;

   state_t         state_q, state_d;
   wr_t            wr_q, wr_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           young_q, young_d;
   logic [31:0]    res_hi_q, res_hi_d, res_lo_q, res_lo_d;
   logic [31:0]    hi_q, hi_d, lo_q, lo_d;

   logic signed [63:0] prod_s;
   logic [63:0]        prod_u, acc_sum, acc_diff;
   logic [31:0]        quo, rem;

   always_comb begin
      prod_s   = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
      prod_u   = {32'd0, A} * {32'd0, B};
      acc_sum  = {hi_q, lo_q} + {res_hi_q, res_lo_q};
      acc_diff = {hi_q, lo_q} - {res_hi_q, res_lo_q};
      quo = 32'd0;
      rem = 32'd0;
      if (B == 32'd0) begin
         quo = 32'd0;
         rem = 32'd0;
      end else if (op[0]) begin
         quo = A / B;
         rem = A % B;
      end else if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
         // The one signed quotient that does not fit: wraps to the dividend
         quo = 32'h8000_0000;
         rem = 32'd0;
      end else begin
         quo = $unsigned($signed(A) / $signed(B));
         rem = $unsigned($signed(A) % $signed(B));
      end
   end

   always_comb begin
      state_d  = state_q;
      wr_d     = wr_q;
      cnt_d    = cnt_q;
      young_d  = young_q;
      res_hi_d = res_hi_q;
      res_lo_d = res_lo_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      case (state_q)
         IDLE: begin
            if (start && !IntReq) begin
               case (op)
                  3'd0, 3'd1: begin
                     {res_hi_d, res_lo_d} = op[0] ? prod_u : prod_s;
                     wr_d    = WR_SET;
                     cnt_d   = CW'(MULT_CYCLES);
                     young_d = 1'b1;
                     state_d = RUN;
                  end
                  3'd2, 3'd3: begin
                     res_lo_d = quo;
                     res_hi_d = rem;
                     wr_d     = (B == 32'd0) ? WR_NONE : WR_SET;
                     cnt_d    = CW'(DIV_CYCLES);
                     young_d  = 1'b1;
                     state_d  = RUN;
                  end
                  3'd4: hi_d = A;
                  3'd5: lo_d = A;
`ifdef MDU_MADD_EN
                  3'd6, 3'd7: begin
                     {res_hi_d, res_lo_d} = prod_s;
                     wr_d    = op[0] ? WR_SUB : WR_ADD;
                     cnt_d   = CW'(MULT_CYCLES);
                     young_d = 1'b1;
                     state_d = RUN;
                  end
`endif
                  default: ;
               endcase
            end
         end
         RUN: begin
            young_d = 1'b0;
            if (IntReq && young_q) begin
               // Issuing instruction is the M-stage victim: drop the result
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CW'(1)) begin
               state_d = IDLE;
               cnt_d   = '0;
               case (wr_q)
                  WR_SET:  {hi_d, lo_d} = {res_hi_q, res_lo_q};
                  WR_ADD:  {hi_d, lo_d} = acc_sum;
                  WR_SUB:  {hi_d, lo_d} = acc_diff;
                  default: ;
               endcase
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q  <= IDLE;
         wr_q     <= WR_SET;
         cnt_q    <= '0;
         young_q  <= 1'b0;
         res_hi_q <= '0;
         res_lo_q <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         wr_q     <= wr_d;
         cnt_q    <= cnt_d;
         young_q  <= young_d;
         res_hi_q <= res_hi_d;
         res_lo_q <= res_lo_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign busy     = (state_q == RUN);
   assign md_stall = start | busy;
   assign HI       = hi_q;
   assign LO       = lo_q;
endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: vector table for mult/div results and latency, plus hand sequences
// for reset, mthi/mtlo under IntReq, interrupt abort window and madd/msub.
module tb_e_mdu;
   logic        clk = 1'b0;
   logic        clr, start, int_req;
   logic [2:0]  op;
   logic [31:0] a_i, b_i;
   logic        busy, md_stall;
   logic [31:0] hi, lo;
   int checks = 0, errors = 0;

   e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .clr(clr), .start(start), .op(op), .A(a_i), .B(b_i),
      .IntReq(int_req), .busy(busy), .md_stall(md_stall), .HI(hi), .LO(lo));

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [2:0]  op;
      logic [31:0] a, b, exp_hi, exp_lo;
      int          cyc;
   } vec_t;
   vec_t vt[10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Presents one op for a single cycle; returns at the negedge after the issue edge.
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic ir);
      @(negedge clk);
      start = 1'b1; op = o; a_i = a; b_i = b; int_req = ir;
      #1 chk("md_stall_on_start", {31'd0, md_stall}, 32'd1);
      @(negedge clk);
      start = 1'b0; int_req = 1'b0; a_i = '0; b_i = '0; op = '0;
   endtask

   task automatic wait_busy(output int n);
      n = 0;
      while (busy && n < 200) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic preset(input logic [31:0] h, input logic [31:0] l);
      issue(3'd4, h, 32'd0, 1'b0);
      issue(3'd5, l, 32'd0, 1'b0);
   endtask

   initial begin
      int n;
      vt[0] = '{"mult_neg1x2",   3'd0, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 5};
      vt[1] = '{"multu_ffx2",    3'd1, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
      vt[2] = '{"multu_max",     3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
      vt[3] = '{"mult_minsq",    3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
      vt[4] = '{"mult_shift",    3'd0, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, 5};
      vt[5] = '{"div_m7_2",      3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
      vt[6] = '{"div_7_m2",      3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
      vt[7] = '{"divu_7_0",      3'd3, 32'd7,        32'd0,        32'h00000055, 32'h00000055, 10};
      vt[8] = '{"div_ovf",       3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
      vt[9] = '{"divu_100_7",    3'd3, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10};

      clr = 1'b1; start = 1'b1; op = 3'd0; a_i = 32'd5; b_i = 32'd3; int_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_hi", hi, 32'd0);
      chk("reset_lo", lo, 32'd0);
      chk("reset_md_stall", {31'd0, md_stall}, 32'd1);
      clr = 1'b0; start = 1'b0; a_i = '0; b_i = '0;
      @(negedge clk);
      chk("post_reset_busy", {31'd0, busy}, 32'd0);

      issue(3'd4, 32'h1234, 32'd0, 1'b0);
      chk("mthi_hi", hi, 32'h1234);
      chk("mthi_busy", {31'd0, busy}, 32'd0);
      issue(3'd4, 32'h9999, 32'd0, 1'b1);
      chk("mthi_int_hi", hi, 32'h1234);
      issue(3'd5, 32'h7777, 32'd0, 1'b1);
      chk("mtlo_int_lo", lo, 32'd0);
      issue(3'd0, 32'd3, 32'd4, 1'b1);
      chk("mult_int_busy", {31'd0, busy}, 32'd0);

      for (int i = 0; i < 10; i++) begin
         preset(32'h55, 32'h55);
         issue(vt[i].op, vt[i].a, vt[i].b, 1'b0);
         wait_busy(n);
         chk({vt[i].name, "_cycles"}, n, vt[i].cyc);
         chk({vt[i].name, "_hi"}, hi, vt[i].exp_hi);
         chk({vt[i].name, "_lo"}, lo, vt[i].exp_lo);
      end

      // Interrupt while the issuing op is the M-stage victim: result dropped
      preset(32'h55, 32'h55);
      issue(3'd0, 32'd3, 32'd4, 1'b0);
      int_req = 1'b1;
      @(negedge clk);
      int_req = 1'b0;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      repeat (6) @(negedge clk);
      chk("abort_hi", hi, 32'h55);
      chk("abort_lo", lo, 32'h55);

      // Interrupt one cycle later: issuing op already retired, completes
      issue(3'd0, 32'd3, 32'd4, 1'b0);
      @(negedge clk);
      int_req = 1'b1;
      @(negedge clk);
      int_req = 1'b0;
      wait_busy(n);
      chk("late_int_cycles", n, 32'd3);
      chk("late_int_hi", hi, 32'd0);
      chk("late_int_lo", lo, 32'd12);

      preset(32'd0, 32'hFFFFFFFF);
      issue(3'd6, 32'd1, 32'd1, 1'b0);
      wait_busy(n);
`ifdef MDU_MADD_EN
      chk("madd_cycles", n, 32'd5);
      chk("madd_hi", hi, 32'd1);
      chk("madd_lo", lo, 32'd0);
      issue(3'd7, 32'd1, 32'd1, 1'b0);
      wait_busy(n);
      chk("msub_cycles", n, 32'd5);
      chk("msub_hi", hi, 32'd0);
      chk("msub_lo", lo, 32'hFFFFFFFF);
`else
      chk("madd_off_cycles", n, 32'd0);
      chk("madd_off_hi", hi, 32'd0);
      chk("madd_off_lo", lo, 32'hFFFFFFFF);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
